uart_tx_buf: RTL

Buffered 8N1 UART transmitter for the scope's serial stimulus and trigger path. Host logic pushes bytes into a small internal FIFO, and the block serializes them onto a registered `TX` line. Framing is one start bit, 8 data bits LSB-first and one stop bit. The bit period is set by a runtime 16-bit baud count, the same convention the team's UART trigger receive path uses, so the two ends interoperate directly with a shared `baud_cnt`.

---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_fifo.sv | 63 ++++++
 rtl/uart_tx_buf.sv | 114 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Constants and FSM state shared by the UART transmit and receive paths.
package uart_pkg;

    typedef enum logic {
        IDLE,
        TXING
    } state_t;

    localparam int FRAME_BITS = 10;
    localparam int BAUD_W     = 16;

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO feeding the UART transmitter.
module uart_tx_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          push, pop;

    // Capacity is judged on the live count; the flags lag it by one cycle.
    always_comb begin
        push     = wr_en && (count_q != CW'(DEPTH));
        pop      = rd_en && (count_q != '0);
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        full_d   = (count_q == CW'(DEPTH));
        empty_d  = (count_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = full_q;
    assign empty   = empty_q;

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 UART transmitter: FIFO, framing FSM, baud and bit counters.
module uart_tx_buf
    import uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BAUD_W-1:0] baud_cnt,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              TX,
    output logic              full,
    output logic              empty,
    output logic              busy,
    output logic              tx_done
);

    localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

    state_t                  state_q, state_d;
    logic [FRAME_BITS-1:0]   tx_sr_q, tx_sr_d;
    logic [BAUD_W-1:0]       baud_lat_q, baud_lat_d;
    logic [BAUD_W-1:0]       baud_ctr_q, baud_ctr_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic                    tx_q, tx_d;
    logic                    done_q, done_d;
    logic                    rd_en;
    logic                    load;
    logic [7:0]              rd_data;

    uart_tx_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .wr_en  (wr_en),
        .wr_data(wr_data),
        .rd_en  (rd_en),
        .rd_data(rd_data),
        .full   (full),
        .empty  (empty)
    );

    always_comb begin
        state_d    = state_q;
        tx_sr_d    = tx_sr_q;
        baud_lat_d = baud_lat_q;
        baud_ctr_d = baud_ctr_q;
        bit_cnt_d  = bit_cnt_q;
        done_d     = 1'b0;
        rd_en      = 1'b0;
        load       = 1'b0;

        unique case (state_q)
            IDLE: begin
                load = !empty;
            end
            TXING: begin
                baud_ctr_d = baud_ctr_q + 1'b1;
                if (baud_ctr_q == baud_lat_q) begin
                    baud_ctr_d = '0;
                    tx_sr_d    = {1'b1, tx_sr_q[FRAME_BITS-1:1]};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == LAST_BIT) begin
                        done_d = 1'b1;
                        if (!empty) begin
                            load = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
        endcase

        // A reload at frame end starts the next start bit with no idle gap.
        if (load) begin
            rd_en      = 1'b1;
            tx_sr_d    = {1'b1, rd_data, 1'b0};
            baud_lat_d = baud_cnt;
            baud_ctr_d = '0;
            bit_cnt_d  = '0;
            state_d    = TXING;
        end

        tx_d = (state_d == TXING) ? tx_sr_d[0] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            tx_sr_q    <= '1;
            baud_lat_q <= '0;
            baud_ctr_q <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            baud_lat_q <= baud_lat_d;
            baud_ctr_q <= baud_ctr_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            done_q     <= done_d;
        end
    end

    assign TX      = tx_q;
    assign busy    = (state_q == TXING);
    assign tx_done = done_q;

endmodule
